// File: rtl/uart_cfg_core.sv
`default_nettype none
// ============================================================================
// Module      : uart_cfg_core
// Description : Full-duplex UART with configurable data width, parity and
//               stop bits. 16x oversampled receiver with false-start
//               rejection, valid/ready byte handshakes on TX and RX, a
//               holding register with per-frame parity/framing flags, a
//               sticky overrun flag, and an internal loopback mode.
// Ports       : clk_i / rst_ni        clock, async active-low reset
//               tx_data_i/tx_valid_i/tx_ready_o   TX byte handshake
//               tx_serial_o / tx_busy_o           TX pin and FSM status
//               rx_serial_i                       async RX pin
//               rx_data_o/rx_valid_o/rx_ready_i   RX byte handshake
//               rx_parity_err_o / rx_frame_err_o  flags of the held frame
//               rx_overrun_o / rx_overrun_clr_i   sticky drop flag + clear
//               rx_busy_o                         RX FSM status
//               loopback_en_i                     route TX line into RX
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cfg_core #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  output logic                  tx_serial_o,
  output logic                  tx_busy_o,
  input  logic                  rx_serial_i,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_valid_o,
  input  logic                  rx_ready_i,
  output logic                  rx_parity_err_o,
  output logic                  rx_frame_err_o,
  output logic                  rx_overrun_o,
  input  logic                  rx_overrun_clr_i,
  output logic                  rx_busy_o,
  input  logic                  loopback_en_i
);

  localparam int unsigned c_div_raw = CLK_FREQ / (BAUD_RATE * 16);
  localparam int unsigned c_div     = (c_div_raw < 1) ? 1 : c_div_raw;
  localparam int unsigned c_tcw     = (c_div > 1) ? $clog2(c_div) : 1;
  localparam logic [3:0]  c_last_data = 4'(DATA_WIDTH - 1);
  localparam logic [3:0]  c_last_stop = 4'(STOP_BITS - 1);
  localparam logic        c_par_odd   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  // --------------------------------------------------------------------------
  // Shared 16x baud tick
  // --------------------------------------------------------------------------
  logic w_tick;

  generate
    if (c_div == 1) begin : g_tick_every_clk
      assign w_tick = 1'b1;
    end else begin : g_tick_div
      logic [c_tcw-1:0] tick_cnt_q;
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          tick_cnt_q <= '0;
        end else if (tick_cnt_q == c_tcw'(c_div - 1)) begin
          tick_cnt_q <= '0;
        end else begin
          tick_cnt_q <= tick_cnt_q + 1'b1;
        end
      end
      assign w_tick = (tick_cnt_q == c_tcw'(c_div - 1));
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Transmitter
  // --------------------------------------------------------------------------
  state_e                tx_state_q;
  logic [3:0]            tx_tick_q;
  logic [3:0]            tx_bit_q;
  logic [DATA_WIDTH-1:0] tx_shift_q;
  logic                  tx_par_q;
  logic                  tx_line_q;   // internal serial line (pre pin mux)
  logic                  tx_ready_q;
  logic                  tx_busy_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_state_q <= ST_IDLE;
      tx_tick_q  <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_line_q  <= 1'b1;
      tx_ready_q <= 1'b1;
      tx_busy_q  <= 1'b0;
    end else if (tx_state_q == ST_IDLE) begin
      if (tx_valid_i && tx_ready_q) begin
        tx_shift_q <= tx_data_i;
        tx_par_q   <= (^tx_data_i) ^ c_par_odd;
        tx_line_q  <= 1'b0;
        tx_ready_q <= 1'b0;
        tx_busy_q  <= 1'b1;
        tx_tick_q  <= '0;
        tx_bit_q   <= '0;
        tx_state_q <= ST_START;
      end
    end else if (w_tick) begin
      if (tx_tick_q != 4'd15) begin
        tx_tick_q <= tx_tick_q + 4'd1;
      end else begin
        // Bit time elapsed: advance and drive the next bit on the line
        tx_tick_q <= '0;
        case (tx_state_q)
          ST_START: begin
            tx_state_q <= ST_DATA;
            tx_line_q  <= tx_shift_q[0];
            tx_shift_q <= tx_shift_q >> 1;
          end
          ST_DATA: begin
            if (tx_bit_q == c_last_data) begin
              tx_bit_q <= '0;
              if (PARITY_EN != 0) begin
                tx_state_q <= ST_PARITY;
                tx_line_q  <= tx_par_q;
              end else begin
                tx_state_q <= ST_STOP;
                tx_line_q  <= 1'b1;
              end
            end else begin
              tx_bit_q   <= tx_bit_q + 4'd1;
              tx_line_q  <= tx_shift_q[0];
              tx_shift_q <= tx_shift_q >> 1;
            end
          end
          ST_PARITY: begin
            tx_state_q <= ST_STOP;
            tx_line_q  <= 1'b1;
          end
          ST_STOP: begin
            if (tx_bit_q == c_last_stop) begin
              // Ready reasserts as IDLE is entered, so a waiting word
              // starts its START bit right after this stop bit.
              tx_state_q <= ST_IDLE;
              tx_ready_q <= 1'b1;
              tx_busy_q  <= 1'b0;
            end else begin
              tx_bit_q <= tx_bit_q + 4'd1;
            end
          end
          default: begin
            tx_state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // Loopback mode register, pin register and RX input synchroniser
  // --------------------------------------------------------------------------
  state_e rx_state_q;
  logic   loop_q;
  logic   tx_pin_q;
  logic   sync1_q;
  logic   sync2_q;
  logic   w_rx_in;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      loop_q   <= 1'b0;
      tx_pin_q <= 1'b1;
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
    end else begin
      // Mode only changes between frames so neither side sees a torn frame
      if (tx_state_q == ST_IDLE && rx_state_q == ST_IDLE) begin
        loop_q <= loopback_en_i;
      end
      tx_pin_q <= tx_line_q | loop_q;
      sync1_q  <= rx_serial_i;
      sync2_q  <= sync1_q;
    end
  end

  assign w_rx_in = loop_q ? tx_line_q : sync2_q;

  // --------------------------------------------------------------------------
  // Receiver and holding register
  // --------------------------------------------------------------------------
  logic [3:0]            rx_tick_q;
  logic [3:0]            rx_bit_q;
  logic [DATA_WIDTH-1:0] rx_shift_q;
  logic                  rx_perr_q;
  logic                  rx_ferr_q;
  logic [DATA_WIDTH-1:0] rx_data_q;
  logic                  rx_valid_q;
  logic                  rx_perr_hold_q;
  logic                  rx_ferr_hold_q;
  logic                  rx_ovr_q;
  logic                  w_rx_mid;
  logic                  w_rx_done;
  logic                  w_frame_err;
  logic                  w_consume;

  assign w_rx_mid    = w_tick && (rx_tick_q == 4'd15);
  assign w_rx_done   = (rx_state_q == ST_STOP) && w_rx_mid && (rx_bit_q == c_last_stop);
  // Include the final stop sample, which is taken on the completing edge
  assign w_frame_err = rx_ferr_q | ~w_rx_in;
  assign w_consume   = rx_valid_q && rx_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_state_q     <= ST_IDLE;
      rx_tick_q      <= '0;
      rx_bit_q       <= '0;
      rx_shift_q     <= '0;
      rx_perr_q      <= 1'b0;
      rx_ferr_q      <= 1'b0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rx_perr_hold_q <= 1'b0;
      rx_ferr_hold_q <= 1'b0;
      rx_ovr_q       <= 1'b0;
    end else begin
      case (rx_state_q)
        ST_IDLE: begin
          if (w_tick && !w_rx_in) begin
            rx_state_q <= ST_START;
            rx_tick_q  <= '0;
            rx_perr_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
          end
        end
        ST_START: begin
          if (w_tick) begin
            if (rx_tick_q == 4'd7) begin
              // Mid start bit: a high level here was only a glitch
              if (w_rx_in) begin
                rx_state_q <= ST_IDLE;
              end else begin
                rx_state_q <= ST_DATA;
                rx_tick_q  <= '0;
                rx_bit_q   <= '0;
              end
            end else begin
              rx_tick_q <= rx_tick_q + 4'd1;
            end
          end
        end
        default: begin
          if (w_tick) begin
            rx_tick_q <= w_rx_mid ? 4'd0 : rx_tick_q + 4'd1;
          end
          if (w_rx_mid) begin
            case (rx_state_q)
              ST_DATA: begin
                rx_shift_q <= {w_rx_in, rx_shift_q[DATA_WIDTH-1:1]};
                if (rx_bit_q == c_last_data) begin
                  rx_bit_q   <= '0;
                  rx_state_q <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                end else begin
                  rx_bit_q <= rx_bit_q + 4'd1;
                end
              end
              ST_PARITY: begin
                rx_perr_q  <= w_rx_in ^ (^rx_shift_q) ^ c_par_odd;
                rx_state_q <= ST_STOP;
              end
              ST_STOP: begin
                if (!w_rx_in) begin
                  rx_ferr_q <= 1'b1;
                end
                if (rx_bit_q == c_last_stop) begin
                  rx_state_q <= ST_IDLE;
                end else begin
                  rx_bit_q <= rx_bit_q + 4'd1;
                end
              end
              default: begin
                rx_state_q <= ST_IDLE;
              end
            endcase
          end
        end
      endcase

      // A consume on the completing edge frees the register for the new frame
      if (w_rx_done && (!rx_valid_q || w_consume)) begin
        rx_data_q      <= rx_shift_q;
        rx_perr_hold_q <= rx_perr_q;
        rx_ferr_hold_q <= w_frame_err;
        rx_valid_q     <= 1'b1;
      end else if (w_consume) begin
        rx_valid_q <= 1'b0;
      end

      if (w_rx_done && rx_valid_q && !rx_ready_i) begin
        rx_ovr_q <= 1'b1;
      end else if (rx_overrun_clr_i) begin
        rx_ovr_q <= 1'b0;
      end
    end
  end

  assign tx_ready_o      = tx_ready_q;
  assign tx_serial_o     = tx_pin_q;
  assign tx_busy_o       = tx_busy_q;
  assign rx_data_o       = rx_data_q;
  assign rx_valid_o      = rx_valid_q;
  assign rx_parity_err_o = rx_perr_hold_q;
  assign rx_frame_err_o  = rx_ferr_hold_q;
  assign rx_overrun_o    = rx_ovr_q;
  assign rx_busy_o       = (rx_state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_cfg_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_cfg_core
// Description : Directed self-checking bench for uart_cfg_core. Instance A is
//               8N1, instance B is 8E2; both at 16 clk per bit (DIV=1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_cfg_core;

  logic clk;
  logic rst_n;

  // instance A (8N1)
  logic [7:0] tx_data_a;
  logic       tx_valid_a, tx_ready_a, tx_serial_a, tx_busy_a;
  logic       rx_serial_a;
  logic [7:0] rx_data_a;
  logic       rx_valid_a, rx_ready_a, rx_perr_a, rx_ferr_a, rx_ovr_a, rx_clr_a;
  logic       rx_busy_a, loop_a;

  // instance B (8E2)
  logic [7:0] tx_data_b;
  logic       tx_valid_b, tx_ready_b, tx_serial_b, tx_busy_b;
  logic       rx_serial_b;
  logic [7:0] rx_data_b;
  logic       rx_valid_b, rx_ready_b, rx_perr_b, rx_ferr_b, rx_ovr_b, rx_clr_b;
  logic       rx_busy_b, loop_b;

  int n_checks = 0;
  int n_fail   = 0;

  uart_cfg_core #(
    .CLK_FREQ(1_600_000), .BAUD_RATE(100_000), .DATA_WIDTH(8),
    .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)
  ) dut_a (
    .clk_i(clk), .rst_ni(rst_n),
    .tx_data_i(tx_data_a), .tx_valid_i(tx_valid_a), .tx_ready_o(tx_ready_a),
    .tx_serial_o(tx_serial_a), .tx_busy_o(tx_busy_a),
    .rx_serial_i(rx_serial_a), .rx_data_o(rx_data_a), .rx_valid_o(rx_valid_a),
    .rx_ready_i(rx_ready_a), .rx_parity_err_o(rx_perr_a), .rx_frame_err_o(rx_ferr_a),
    .rx_overrun_o(rx_ovr_a), .rx_overrun_clr_i(rx_clr_a), .rx_busy_o(rx_busy_a),
    .loopback_en_i(loop_a)
  );

  uart_cfg_core #(
    .CLK_FREQ(1_600_000), .BAUD_RATE(100_000), .DATA_WIDTH(8),
    .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)
  ) dut_b (
    .clk_i(clk), .rst_ni(rst_n),
    .tx_data_i(tx_data_b), .tx_valid_i(tx_valid_b), .tx_ready_o(tx_ready_b),
    .tx_serial_o(tx_serial_b), .tx_busy_o(tx_busy_b),
    .rx_serial_i(rx_serial_b), .rx_data_o(rx_data_b), .rx_valid_o(rx_valid_b),
    .rx_ready_i(rx_ready_b), .rx_parity_err_o(rx_perr_b), .rx_frame_err_o(rx_ferr_b),
    .rx_overrun_o(rx_ovr_b), .rx_overrun_clr_i(rx_clr_b), .rx_busy_o(rx_busy_b),
    .loopback_en_i(loop_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive nb serial bits (LSB first) for 16 clk each, then return line high.
  task automatic send_bits(input bit sel, input logic [15:0] bits, input int nb);
    for (int i = 0; i < nb; i++) begin
      if (sel) rx_serial_b = bits[i];
      else     rx_serial_a = bits[i];
      repeat (16) @(negedge clk);
    end
    if (sel) rx_serial_b = 1'b1;
    else     rx_serial_a = 1'b1;
  endtask

  logic [9:0] line_bits;
  logic [9:0] f1_bits, f2_bits;
  logic       pins [0:339];
  logic       all_high, busy_mid, busy_late, valid_seen;
  int         lat, valid_cycles, start1, start2, phase;
  logic [7:0] got_data;
  logic       got_perr, got_ferr;

  initial begin
    rst_n = 1'b0;
    tx_data_a = '0; tx_valid_a = 0; rx_serial_a = 1; rx_ready_a = 0; rx_clr_a = 0; loop_a = 0;
    tx_data_b = '0; tx_valid_b = 0; rx_serial_b = 1; rx_ready_b = 0; rx_clr_b = 0; loop_b = 0;
    repeat (3) @(negedge clk);

    // ---------------- reset state ----------------
    check_val("rst_tx_serial", tx_serial_a, 1);
    check_val("rst_tx_ready",  tx_ready_a,  1);
    check_val("rst_tx_busy",   tx_busy_a,   0);
    check_val("rst_rx_valid",  rx_valid_a,  0);
    check_val("rst_rx_data",   rx_data_a,   0);
    check_val("rst_rx_flags",  {rx_perr_a, rx_ferr_a, rx_ovr_a, rx_busy_a}, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // ---------------- 8N1 loopback of 0xA5 ----------------
    loop_a = 1; rx_ready_a = 1;
    repeat (3) @(negedge clk);
    tx_data_a = 8'hA5; tx_valid_a = 1;
    @(negedge clk);                        // n=0: accept edge just passed
    tx_valid_a = 0;
    check_val("lb_tx_ready_drop", tx_ready_a, 0);
    check_val("lb_tx_busy", tx_busy_a, 1);
    all_high = 1; valid_cycles = 0; lat = -1; got_data = '0; got_perr = 1; got_ferr = 1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      all_high &= tx_serial_a;
      if ((n % 16) == 8 && (n / 16) < 10) line_bits[n/16] = dut_a.tx_line_q;
      if (rx_valid_a) begin
        valid_cycles++;
        if (lat < 0) begin
          lat = n; got_data = rx_data_a; got_perr = rx_perr_a; got_ferr = rx_ferr_a;
        end
      end
    end
    check_val("lb_pin_high", all_high, 1);
    check_val("lb_line_bits", line_bits, {1'b1, 8'hA5, 1'b0});
    check_val("lb_rx_data", got_data, 8'hA5);
    check_val("lb_rx_flags", {got_perr, got_ferr}, 0);
    // detect at +1, start mid +9, 8 data + 1 stop at 16-clk steps -> +153
    check_val("lb_latency", lat, 153);
    check_val("lb_valid_pulse", valid_cycles, 1);
    check_val("lb_tx_idle", {tx_ready_a, tx_busy_a}, 2'b10);

    // ---------------- overrun (external, 8N1) ----------------
    loop_a = 0; rx_ready_a = 0;
    repeat (4) @(negedge clk);
    send_bits(0, {6'h3f, 1'b1, 8'h11, 1'b0}, 10);
    check_val("ovr_first_valid", rx_valid_a, 1);
    check_val("ovr_first_data", rx_data_a, 8'h11);
    check_val("ovr_first_flag", rx_ovr_a, 0);
    send_bits(0, {6'h3f, 1'b1, 8'h22, 1'b0}, 10);
    check_val("ovr_data_kept", rx_data_a, 8'h11);
    check_val("ovr_set", rx_ovr_a, 1);
    rx_clr_a = 1; @(negedge clk); rx_clr_a = 0;
    check_val("ovr_clr", rx_ovr_a, 0);
    check_val("ovr_still_valid", rx_valid_a, 1);
    rx_ready_a = 1; @(negedge clk);
    check_val("ovr_consumed", rx_valid_a, 0);

    // ---------------- false start ----------------
    repeat (20) @(negedge clk);
    rx_serial_a = 0;
    busy_mid = 0; busy_late = 1; valid_seen = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 5) begin
        busy_mid = rx_busy_a;
        rx_serial_a = 1;
      end
      if (k == 12) busy_late = rx_busy_a;
      valid_seen |= rx_valid_a;
    end
    check_val("fs_busy_during", busy_mid, 1);
    check_val("fs_busy_cleared", busy_late, 0);
    check_val("fs_no_valid", valid_seen, 0);

    // ---------------- back-to-back TX 0x55, 0xAA ----------------
    tx_data_a = 8'h55; tx_valid_a = 1; phase = 0;
    @(negedge clk);
    tx_data_a = 8'hAA;
    for (int n = 0; n < 340; n++) begin
      if (n > 0) @(negedge clk);
      pins[n] = tx_serial_a;
      if (phase == 0 && tx_ready_a) phase = 1;
      else if (phase == 1 && !tx_ready_a) begin
        tx_valid_a = 0; phase = 2;
      end
    end
    start1 = -1; start2 = -1;
    for (int n = 0; n < 340; n++) if (start1 < 0 && pins[n] == 1'b0) start1 = n;
    for (int n = 150; n < 340; n++) if (start2 < 0 && pins[n] == 1'b0) start2 = n;
    check_val("b2b_start1", start1, 1);
    // 160 clk frame + 1 clk handshake cycle in IDLE
    check_val("b2b_start2", start2, 162);
    for (int k = 0; k < 10; k++) begin
      f1_bits[k] = pins[start1 + 16*k + 8];
      f2_bits[k] = (start2 > 0) ? pins[(start2 + 16*k + 8) % 340] : 1'bx;
    end
    check_val("b2b_frame1", f1_bits, {1'b1, 8'h55, 1'b0});
    check_val("b2b_frame2", f2_bits, {1'b1, 8'hAA, 1'b0});

    // ---------------- 8E2 parity / framing (instance B) ----------------
    // 0x03 has two ones: even parity bit is 0
    send_bits(1, {4'hf, 1'b1, 1'b1, 1'b1, 8'h03, 1'b0}, 12);
    check_val("par_bad_valid", rx_valid_b, 1);
    check_val("par_bad_data", rx_data_b, 8'h03);
    check_val("par_bad_flags", {rx_perr_b, rx_ferr_b}, 2'b10);
    rx_ready_b = 1; @(negedge clk); rx_ready_b = 0;
    check_val("par_consumed", rx_valid_b, 0);
    send_bits(1, {4'hf, 1'b1, 1'b1, 1'b0, 8'h03, 1'b0}, 12);
    check_val("par_ok_flags", {rx_valid_b, rx_perr_b, rx_ferr_b}, 3'b100);
    rx_ready_b = 1; @(negedge clk); rx_ready_b = 0;
    send_bits(1, {4'hf, 1'b0, 1'b1, 1'b0, 8'h03, 1'b0}, 12);
    repeat (20) @(negedge clk);
    check_val("stop2_low_flags", {rx_valid_b, rx_perr_b, rx_ferr_b}, 3'b101);
    send_bits(1, {4'hf, 1'b1, 1'b1, 1'b0, 8'h5a, 1'b0}, 12);
    check_val("b_ovr_set", {rx_ovr_b, rx_data_b}, {1'b1, 8'h03});

    // ---------------- async reset mid-TX ----------------
    tx_data_a = 8'hA5; tx_valid_a = 1;
    @(negedge clk);
    tx_valid_a = 0;
    repeat (8) @(negedge clk);
    check_val("mid_tx_start_low", {tx_serial_a, tx_busy_a}, 2'b01);
    #2 rst_n = 0;
    #1;
    check_val("arst_tx", {tx_serial_a, tx_ready_a, tx_busy_a}, 3'b110);
    check_val("arst_rx_a", {rx_valid_a, rx_perr_a, rx_ferr_a, rx_ovr_a, rx_busy_a}, 0);
    check_val("arst_rx_b", {rx_valid_b, rx_perr_b, rx_ferr_b, rx_ovr_b, rx_data_b}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_cfg_core.md
Name: uart_cfg_core

Overview:
Parametrised full-duplex UART core: configurable data width, parity mode and stop-bit count, 16x oversampled receiver with false-start rejection, and valid/ready handshakes on both the TX and RX byte interfaces. The RX side holds received data, with per-frame parity/framing flags and sticky overrun. A runtime loopback mode routes TX serial into RX internally, for self-test without the top-level wire tie used today. It sits between the system bus logic and the pad-level serial pins.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
BAUD_RATE, 115200, serial bit rate
DATA_WIDTH, 8, data bits per frame, legal 5..9
PARITY_EN, 0, 1 = parity bit appended after data
PARITY_ODD, 0, 1 = odd parity, 0 = even (ignored when PARITY_EN=0)
STOP_BITS, 1, stop bits per frame, legal 1 or 2

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
tx_data  in  DATA_WIDTH  byte to transmit
tx_valid  in  1  tx_data valid
tx_ready  out  1  core can accept tx_data
tx_serial  out  1  serial output pin, idle high
tx_busy  out  1  TX FSM not in IDLE
rx_serial  in  1  serial input pin, asynchronous
rx_data  out  DATA_WIDTH  received data
rx_valid  out  1  rx_data/flags valid, held until consumed
rx_ready  in  1  consumer accepts rx_data
rx_parity_err  out  1  parity mismatch on the frame in rx_data
rx_frame_err  out  1  stop bit sampled low on the frame in rx_data
rx_overrun  out  1  sticky: a frame was dropped because the holding register was full
rx_overrun_clr  in  1  one-cycle pulse clears rx_overrun
rx_busy  out  1  RX FSM not in IDLE
loopback_en  in  1  1 = RX fed from internal TX, tx_serial pin held high

Behaviour:
- Reset (async, rst_n low): tx_serial=1, tx_ready=1, tx_busy=0, rx_valid=0, rx_data=0, all error flags 0, rx_busy=0, both FSMs in IDLE, tick counter 0, sync flops 1.
- Tick generator: DIV = CLK_FREQ/(BAUD_RATE*16), integer-truncated, min 1. Counter 0..DIV-1 emits a one-cycle tick on wrap. One bit = 16 ticks. Free-running and shared by TX and RX.
- TX handshake: transfer on tx_valid && tx_ready. tx_data is captured into a shift register, tx_ready drops the next cycle, and the FSM leaves IDLE.
- TX FSM: IDLE -> START (0) -> DATA (DATA_WIDTH bits, LSB first) -> PARITY (only if PARITY_EN) -> STOP (1, STOP_BITS bit times) -> IDLE.
  - Each non-IDLE state lasts 16 ticks. tx_serial is registered.
  - Parity bit = XOR of data bits, inverted when PARITY_ODD.
  - tx_ready reasserts in the cycle the FSM returns to IDLE. A transfer accepted in that cycle starts the next START bit with no extra idle bits.
- RX input: rx_serial passes through a 2-flop synchroniser. Effective input = loopback_en ? internal TX line : synchronised rx_serial.
- RX FSM: IDLE -> START on a low level at a tick.
  - START: at tick 8, input high -> false start, back to IDLE with no flags; low -> counter reset, go to DATA.
  - DATA: sample at each bit midpoint (16 ticks apart), shift in LSB first.
  - PARITY (if enabled): sample and compare.
  - STOP: sample at mid of each stop bit. Any low sample -> frame error.
  - Frame completes at mid of last stop bit, then return to IDLE.
- RX holding: on frame completion with rx_valid=0, load rx_data, rx_parity_err and rx_frame_err, and set rx_valid the next cycle.
  - rx_valid holds until rx_valid && rx_ready, which clears it the following cycle.
  - Frame completion with rx_valid=1 and rx_ready=0 in the same cycle: new frame discarded, holding register unchanged, rx_overrun set.
  - Completion and consume in the same cycle: consume wins first, the new frame loads, no overrun.
- rx_overrun stays set until an rx_overrun_clr pulse. Set and clear in the same cycle: set wins.
- loopback_en is sampled into an internal mode register only when both FSMs are IDLE. Changes mid-frame take effect after both go idle.
- DATA_WIDTH=9: the parity bit follows bit 8. Frame length = 1 + DATA_WIDTH + PARITY_EN + STOP_BITS bits.
- Reset mid-frame: both FSMs return to IDLE immediately, tx_serial=1, and the partial frame is lost.

Test Plan:
Bench uses CLK_FREQ=1_600_000, BAUD_RATE=100_000 (DIV=1, 16 clk/bit).
- Reset: hold rst_n low mid-TX of 0xA5 -> tx_serial=1, tx_ready=1, rx_valid=0 and all flags 0 within the same cycle (async).
- 8N1 loopback: loopback_en=1, send 0xA5 with rx_ready=1 -> tx_serial pin stays 1; internal line reads 0,1,0,1,0,0,1,0,1,1; rx_valid pulses with rx_data=0xA5, no error flags; rx_valid follows TX acceptance by ≈152 clk + sync.
- 8E2 external: PARITY_EN=1, STOP_BITS=2, drive rx_serial with 0x03 and parity bit 1 -> rx_parity_err=1; repeat with parity bit 0 -> flag 0; drive the 2nd stop bit low -> rx_frame_err=1.
- Overrun: rx_ready=0, receive 0x11 then 0x22 -> rx_data stays 0x11 and rx_overrun=1; pulse rx_overrun_clr -> 0; raise rx_ready -> 0x11 consumed, rx_valid=0.
- False start: drive rx_serial low for 5 clk, then high -> no rx_valid, rx_busy back to 0 by clk 10.
- Back-to-back TX: hold tx_valid=1 with 0x55 then 0xAA -> second START bit begins immediately after the first stop bit, with zero extra idle bits.
